// File: rtl/i2c_master_tx.sv
// Write-only I2C master serializer: START, N bytes MSB-first (8 SCL pulses, no ACK), STOP.
// SCL timing is built from quarter periods of CLK_DIV system clocks.
module i2c_master_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       scl,
   output logic       sda,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBit,
      StWait,
      StStop
   } state_e;

   localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       last_q, last_d;
   logic       done_q, done_d;
   logic       tick;

   assign tick = (div_cnt_q == DivMax);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         div_cnt_q <= '0;
         qtr_q     <= '0;
         bit_idx_q <= 3'd7;
         shreg_q   <= '0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         qtr_q     <= qtr_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         last_q    <= last_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_cnt_d = tick ? '0 : div_cnt_q + 8'd1;
      qtr_d     = tick ? qtr_q + 2'd1 : qtr_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      last_d    = last_q;
      done_d    = 1'b0;
      scl       = 1'b1;
      sda       = 1'b1;
      tx_ready  = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_ready  = 1'b1;
            div_cnt_d = '0;
            qtr_d     = '0;
            if (tx_valid) begin
               shreg_d = tx_data;
               last_d  = tx_last;
               state_d = StStart;
            end
         end

         StStart: begin
            scl = (qtr_q == 2'd0);
            sda = 1'b0;
            if (tick && qtr_q == 2'd1) begin
               state_d   = StBit;
               bit_idx_d = 3'd7;
               div_cnt_d = '0;
               qtr_d     = '0;
            end
         end

         StBit: begin
            // Quarters 0-1 low, 2-3 high; data is stable for the whole bit.
            scl = qtr_q[1];
            sda = shreg_q[bit_idx_q];
            if (tick && qtr_q == 2'd3) begin
               div_cnt_d = '0;
               qtr_d     = '0;
               if (bit_idx_q != 3'd0) begin
                  bit_idx_d = bit_idx_q - 3'd1;
               end else if (last_q) begin
                  state_d = StStop;
               end else begin
                  state_d = StWait;
               end
            end
         end

         StWait: begin
            // Clock stretch: SCL held low, SDA keeps bit 0 until the next byte arrives.
            scl       = 1'b0;
            sda       = shreg_q[0];
            tx_ready  = 1'b1;
            div_cnt_d = '0;
            qtr_d     = '0;
            if (tx_valid) begin
               shreg_d   = tx_data;
               last_d    = tx_last;
               bit_idx_d = 3'd7;
               state_d   = StBit;
            end
         end

         StStop: begin
            scl = (qtr_q != 2'd0);
            sda = (qtr_q == 2'd2);
            if (tick && qtr_q == 2'd2) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               div_cnt_d = '0;
               qtr_d     = '0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;

endmodule
